// File: rtl/ifu_idu_skid_reg_ysyx23060136.sv
// Two-entry skid buffer between the instruction fetch unit and the decoder.
// The head slot drives idu_*. The skid slot catches the one word that the IFU
// can still hand over in the cycle the decoder stalls. Every output comes
// straight from a flop, so ifu_ready never depends on idu_ready.
module ifu_idu_skid_reg_ysyx23060136 #(
  parameter logic [31:0] RST_PC   = 32'h8000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_valid,
  output logic        ifu_ready,
  input  logic [31:0] ifu_inst,
  input  logic [31:0] ifu_pc,
  output logic        idu_valid,
  input  logic        idu_ready,
  output logic [31:0] idu_inst,
  output logic [31:0] idu_pc,
  input  logic        flush,
  output logic [1:0]  occupancy
);

  // The state encoding is the number of live entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        ifu_ready_q, ifu_ready_d;
  logic        idu_valid_q, idu_valid_d;
  logic [31:0] head_inst_q, head_inst_d;
  logic [31:0] head_pc_q, head_pc_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = ifu_valid & ifu_ready_q;
  assign out_xfer = idu_valid_q & idu_ready;

  // State, handshake flags and both data slots, all returned to known values on reset.
  // NOTE: the data slots are reset as well. They are only two words wide, and the
  // reset values are visible on idu_* while the buffer is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the values that held before the edge.
      state_q     <= EMPTY;
      ifu_ready_q <= 1'b1;
      idu_valid_q <= 1'b0;
      head_inst_q <= NOP_INST;
      head_pc_q   <= RST_PC;
      skid_inst_q <= NOP_INST;
      skid_pc_q   <= RST_PC;
    end else begin
      state_q     <= state_d;
      ifu_ready_q <= ifu_ready_d;
      idu_valid_q <= idu_valid_d;
      head_inst_q <= head_inst_d;
      head_pc_q   <= head_pc_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
    end
  end

  // Next state and slot updates. Flush overrides every transfer in the same cycle.
  always_comb begin
    // NOTE: every signal gets a hold default first, so no path leaves it unassigned
    // and no latch is inferred.
    state_d     = state_q;
    head_inst_d = head_inst_q;
    head_pc_d   = head_pc_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;

    if (flush) begin
      // Wrong-path work is dropped. idu_pc keeps the pc that was last presented.
      state_d     = EMPTY;
      head_inst_d = NOP_INST;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d     = ONE;
            head_inst_d = ifu_inst;
            head_pc_d   = ifu_pc;
          end
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            head_inst_d = ifu_inst;
            head_pc_d   = ifu_pc;
          end else if (in_xfer) begin
            state_d     = FULL;
            skid_inst_d = ifu_inst;
            skid_pc_d   = ifu_pc;
          end else if (out_xfer) begin
            state_d     = EMPTY;
            head_inst_d = NOP_INST;
          end
        end
        FULL: begin
          // No word can arrive here because ifu_ready is low in FULL.
          if (out_xfer) begin
            state_d     = ONE;
            head_inst_d = skid_inst_q;
            head_pc_d   = skid_pc_q;
          end
        end
        default: begin
          state_d     = EMPTY;
          head_inst_d = NOP_INST;
        end
      endcase
    end

    ifu_ready_d = (state_d != FULL);
    idu_valid_d = (state_d != EMPTY);
  end

  assign ifu_ready = ifu_ready_q;
  assign idu_valid = idu_valid_q;
  assign idu_inst  = head_inst_q;
  assign idu_pc    = head_pc_q;
  assign occupancy = state_q;

endmodule
